// File: rtl/pipeline_pkg.sv
// Shared pipeline constants and the IF/ID register layout used by if_stage and id_stage.
package pipeline_pkg;

  localparam int unsigned XLEN = 32;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [XLEN-1:0] RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic            valid;
    logic [31:0]     instr;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;
  } if_id_t;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: bubble beats load, otherwise hold.
import pipeline_pkg::*;

module if_id_reg #(
  parameter logic [31:0] NOP = pipeline_pkg::NOP_INSTR
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   load,
  input  logic   bubble,
  input  if_id_t d,
  output if_id_t q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q.valid    <= 1'b0;
      q.instr    <= NOP;
      q.pc       <= '0;
      q.pc_plus4 <= '0;
    end else if (bubble) begin
      // pc fields keep their old values so trace output stays stable across bubbles
      q.valid <= 1'b0;
      q.instr <= NOP;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, next-PC selection, fetch counter and
// sticky misalignment flag; feeds the IF/ID register.
import pipeline_pkg::*;

module if_stage #(
  parameter int unsigned          XLEN        = pipeline_pkg::XLEN,
  parameter logic [XLEN-1:0]      RESET_PC    = pipeline_pkg::RESET_PC,
  parameter int unsigned          IMEM_ADDR_W = 10,
  parameter logic [31:0]          NOP_INSTR   = pipeline_pkg::NOP_INSTR
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic [IMEM_ADDR_W-1:0] imem_addr,
  input  logic [31:0]            imem_rdata,
  input  logic                   stall,
  input  logic                   flush,
  input  logic                   redirect_valid,
  input  logic [XLEN-1:0]        redirect_pc,
  output logic                   if_id_valid,
  output logic [31:0]            if_id_instr,
  output logic [XLEN-1:0]        if_id_pc,
  output logic [XLEN-1:0]        if_id_pc_plus4,
  output logic [XLEN-1:0]        pc_out,
  output logic [31:0]            fetch_count,
  output logic                   misalign_err
);

  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] pc_plus4;
  logic            load;
  logic            bubble;
  if_id_t          if_id_d;
  if_id_t          if_id_q;

  // Flow control: there is no ready; stall is the only back-pressure and
  // freezes everything. if_id_valid marks a real instruction, and it only
  // rises on an edge with no redirect, no flush and no stall.
  assign pc_plus4  = pc_q + XLEN'(4);
  assign imem_addr = pc_q[IMEM_ADDR_W+1:2];
  assign bubble    = redirect_valid | flush;
  assign load      = ~redirect_valid & ~flush & ~stall;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q         <= RESET_PC;
      fetch_count  <= '0;
      misalign_err <= 1'b0;
    end else if (redirect_valid) begin
      pc_q <= {redirect_pc[XLEN-1:2], 2'b00};
      if (redirect_pc[1:0] != 2'b00) misalign_err <= 1'b1;
    end else if (flush) begin
      if (!stall) pc_q <= pc_plus4;
    end else if (!stall) begin
      pc_q        <= pc_plus4;
      fetch_count <= fetch_count + 32'd1;
    end
  end

  always_comb begin
    if_id_d          = '0;
    if_id_d.valid    = 1'b1;
    if_id_d.instr    = imem_rdata;
    if_id_d.pc       = pc_q;
    if_id_d.pc_plus4 = pc_plus4;
  end

  if_id_reg #(.NOP(NOP_INSTR)) u_if_id_reg (
    .clk    (clk),
    .rst    (rst),
    .load   (load),
    .bubble (bubble),
    .d      (if_id_d),
    .q      (if_id_q)
  );

  assign if_id_valid    = if_id_q.valid;
  assign if_id_instr    = if_id_q.instr;
  assign if_id_pc       = if_id_q.pc;
  assign if_id_pc_plus4 = if_id_q.pc_plus4;
  assign pc_out         = pc_q;

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: expected IF/ID contents are queued as each step
// is driven and popped when the register updates.
module tb_if_stage;

  localparam int W = 97;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [9:0]  imem_addr;
  logic [31:0] imem_rdata;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        if_id_valid;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_pc_plus4;
  logic [31:0] pc_out;
  logic [31:0] fetch_count;
  logic        misalign_err;

  logic [31:0] mem [0:1023];
  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  // clock / reset
  always #5 clk = ~clk;

  assign imem_rdata = mem[imem_addr];

  if_stage dut (
    .clk            (clk),
    .rst            (rst),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .stall          (stall),
    .flush          (flush),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .if_id_valid    (if_id_valid),
    .if_id_instr    (if_id_instr),
    .if_id_pc       (if_id_pc),
    .if_id_pc_plus4 (if_id_pc_plus4),
    .pc_out         (pc_out),
    .fetch_count    (fetch_count),
    .misalign_err   (misalign_err)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic push_exp(input logic v, input logic [31:0] instr, input logic [31:0] pc,
                          input logic [31:0] pc4);
    exp_q.push_back({v, instr, pc, pc4});
  endtask

  // drive one edge's worth of control, then pop and compare IF/ID
  task automatic step(input logic rv, input logic [31:0] rpc, input logic st, input logic fl);
    logic [W-1:0] exp;
    redirect_valid = rv;
    redirect_pc    = rpc;
    stall          = st;
    flush          = fl;
    @(posedge clk);
    #1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    stall          = 1'b0;
    flush          = 1'b0;
    if (exp_q.size() == 0) begin
      check("exp_q_underflow", 128'(exp_q.size()), 128'd1);
    end else begin
      exp = exp_q.pop_front();
      check("if_id", 128'({if_id_valid, if_id_instr, if_id_pc, if_id_pc_plus4}), 128'(exp));
    end
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_valid"}, 128'(if_id_valid), 128'd0);
    check({tag, "_instr"}, 128'(if_id_instr), 128'(NOP));
    check({tag, "_pc"}, 128'(if_id_pc), 128'd0);
    check({tag, "_pc4"}, 128'(if_id_pc_plus4), 128'd0);
    check({tag, "_pc_out"}, 128'(pc_out), 128'd0);
    check({tag, "_fetch_count"}, 128'(fetch_count), 128'd0);
    check({tag, "_misalign"}, 128'(misalign_err), 128'd0);
    check({tag, "_imem_addr"}, 128'(imem_addr), 128'd0);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = $urandom_range(32'h7fff_ffff, 0);
    mem[0] = 32'h00A0_0293;
    mem[1] = 32'h0142_8313;

    // reset asserted before any clock edge
    #1 rst = 1'b1;
    #1 check_reset_state("reset");
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;

    // basic fetch
    push_exp(1'b1, mem[0], 32'h0, 32'h4);
    step(1'b0, 32'h0, 1'b0, 1'b0);
    check("pc_after_first", 128'(pc_out), 128'h4);
    push_exp(1'b1, mem[1], 32'h4, 32'h8);
    step(1'b0, 32'h0, 1'b0, 1'b0);
    check("fetch_count_2", 128'(fetch_count), 128'd2);
    check("pc_out_8", 128'(pc_out), 128'h8);

    // stall holds everything
    for (int i = 0; i < 3; i++) begin
      push_exp(1'b1, mem[1], 32'h4, 32'h8);
      step(1'b0, 32'h0, 1'b1, 1'b0);
      check("stall_imem_addr", 128'(imem_addr), 128'd2);
      check("stall_fetch_count", 128'(fetch_count), 128'd2);
    end
    push_exp(1'b1, mem[2], 32'h8, 32'hC);
    step(1'b0, 32'h0, 1'b0, 1'b0);
    check("post_stall_count", 128'(fetch_count), 128'd3);

    // redirect
    push_exp(1'b0, NOP, 32'h8, 32'hC);
    step(1'b1, 32'h40, 1'b0, 1'b0);
    check("redirect_pc", 128'(pc_out), 128'h40);
    check("redirect_count", 128'(fetch_count), 128'd3);
    push_exp(1'b1, mem[16], 32'h40, 32'h44);
    step(1'b0, 32'h0, 1'b0, 1'b0);
    check("after_redirect_count", 128'(fetch_count), 128'd4);

    // redirect wins over stall and flush
    push_exp(1'b0, NOP, 32'h40, 32'h44);
    step(1'b1, 32'h80, 1'b1, 1'b1);
    check("prio_pc", 128'(pc_out), 128'h80);
    check("prio_count", 128'(fetch_count), 128'd4);
    // flush alone advances pc
    push_exp(1'b0, NOP, 32'h40, 32'h44);
    step(1'b0, 32'h0, 1'b0, 1'b1);
    check("flush_pc", 128'(pc_out), 128'h84);
    // flush with stall holds pc
    push_exp(1'b0, NOP, 32'h40, 32'h44);
    step(1'b0, 32'h0, 1'b1, 1'b1);
    check("flush_stall_pc", 128'(pc_out), 128'h84);
    check("flush_count", 128'(fetch_count), 128'd4);
    push_exp(1'b1, mem[33], 32'h84, 32'h88);
    step(1'b0, 32'h0, 1'b0, 1'b0);
    check("resume_count", 128'(fetch_count), 128'd5);

    // misaligned redirect: target aligned, flag sticky
    push_exp(1'b0, NOP, 32'h84, 32'h88);
    step(1'b1, 32'h42, 1'b0, 1'b0);
    check("misalign_set", 128'(misalign_err), 128'd1);
    check("misalign_pc", 128'(pc_out), 128'h40);
    for (int i = 0; i < 10; i++) begin
      push_exp(1'b1, mem[16+i], 32'h40 + 32'(4*i), 32'h44 + 32'(4*i));
      step(1'b0, 32'h0, 1'b0, 1'b0);
      check("misalign_sticky", 128'(misalign_err), 128'd1);
    end
    check("count_15", 128'(fetch_count), 128'd15);

    // async reset mid-cycle at pc 0x20
    push_exp(1'b0, NOP, 32'h64, 32'h68);
    step(1'b1, 32'h20, 1'b0, 1'b0);
    check("pre_reset_pc", 128'(pc_out), 128'h20);
    #2 rst = 1'b1;
    #1 check_reset_state("async_reset");
    @(negedge clk) rst = 1'b0;
    push_exp(1'b1, mem[0], 32'h0, 32'h4);
    step(1'b0, 32'h0, 1'b0, 1'b0);
    check("post_reset_count", 128'(fetch_count), 128'd1);

    // PC wrap at top of address space; imem_addr aliases
    push_exp(1'b0, NOP, 32'h0, 32'h4);
    step(1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0);
    check("wrap_imem_addr", 128'(imem_addr), 128'h3FF);
    push_exp(1'b1, mem[1023], 32'hFFFF_FFFC, 32'h0);
    step(1'b0, 32'h0, 1'b0, 1'b0);
    check("wrap_pc_out", 128'(pc_out), 128'h0);
    check("wrap_count", 128'(fetch_count), 128'd2);

    check("exp_q_drained", 128'(exp_q.size()), 128'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
